// File: rtl/farbborg_pkg.sv
// farbborg_pkg: shared state encoding, widths and lane extraction for the scan engine
package farbborg_pkg;
  localparam int FB_ADR_W = 8;
  localparam int LANES = 8;
  localparam int MAX_W = 16;
  typedef enum logic [3:0] {IDLE, CLR, ADDR, DATA, CLKH, CLKL, PSR_H, PSR_L, SHOW} state_t;
  function automatic logic [MAX_W-1:0] lane(input logic [LANES*MAX_W-1:0] dat, input int unsigned w, input int unsigned k);
    logic [LANES*MAX_W-1:0] s;
    s = dat >> (k * w);
    return s[MAX_W-1:0] & MAX_W'((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/farbborg_pwm_cmp.sv
// farbborg_pwm_cmp: registered brightness-vs-step comparison for the 8 column lanes
module farbborg_pwm_cmp import farbborg_pkg::*; #(
  parameter int PWM_BITS = 8
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [PWM_BITS-1:0]       step,
  input  logic [LANES*PWM_BITS-1:0] fb_dat,
  output logic [LANES-1:0]          col_data
);
  logic [LANES*MAX_W-1:0] dat;
  assign dat = (LANES*MAX_W)'(fb_dat);
  always_ff @(posedge clk or posedge reset)
    if (reset) col_data <= '0;
    else if (load)
      for (int k = 0; k < LANES; k++) col_data[k] <= lane(dat, PWM_BITS, k) > MAX_W'(step);
endmodule

// File: rtl/farbborg_scan.sv
// farbborg_scan: PWM display scan of the LED cube; shifts column data per plane, selects
// the plane, lights it for ON_CYCLES and pulses frame_done at the end of each PWM frame.
module farbborg_scan import farbborg_pkg::*; #(
  parameter int NUM_PLANES = 5,
  parameter int LSR_LEN = 10,
  parameter int PWM_BITS = 8,
  parameter int ON_CYCLES = 16
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic [FB_ADR_W-1:0]       fb_adr,
  input  logic [LANES*PWM_BITS-1:0] fb_dat,
  output logic [LANES-1:0]          col_data,
  output logic                      lsr_c,
  output logic                      lsr_clr,
  output logic                      psr_c,
  output logic                      psr_d,
  output logic                      col_enable,
  output logic                      frame_done
);
  localparam int CNT_W = $clog2(ON_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] STEP_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
  state_t state, nxt;
  logic [3:0] plane, pos, plane_n, pos_n;
  logic [PWM_BITS-1:0] step, step_n;
  logic [CNT_W-1:0] cnt;
  logic show_end, last_plane, last_pos, wrap;
  assign show_end = state == SHOW && cnt == CNT_W'(ON_CYCLES - 1);
  assign last_plane = plane == 4'(NUM_PLANES - 1);
  assign last_pos = pos == 4'(LSR_LEN - 1);
  assign wrap = step == STEP_MAX;
  always_comb begin
    nxt = state;
    plane_n = plane;
    pos_n = pos;
    step_n = step;
    case (state)
      IDLE:  nxt = CLR;
      CLR:   nxt = ADDR;
      ADDR:  nxt = DATA;
      DATA:  nxt = CLKH;
      CLKH:  nxt = CLKL;
      CLKL: begin
        nxt = last_pos ? PSR_H : ADDR;
        pos_n = last_pos ? 4'd0 : pos + 4'd1;
      end
      PSR_H: nxt = PSR_L;
      PSR_L: nxt = SHOW;
      SHOW: if (show_end) begin
        nxt = ADDR;
        plane_n = last_plane ? 4'd0 : plane + 4'd1;
        step_n = !last_plane ? step : wrap ? '0 : step + 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (!enable) begin
      nxt = IDLE;
      plane_n = '0;
      pos_n = '0;
      step_n = '0;
    end
  end
  // Outputs are registered from the next state so strobes never glitch.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      plane <= '0;
      pos <= '0;
      step <= '0;
      cnt <= '0;
      fb_adr <= '0;
      lsr_c <= 1'b0;
      lsr_clr <= 1'b1;
      psr_c <= 1'b0;
      psr_d <= 1'b0;
      col_enable <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      plane <= plane_n;
      pos <= pos_n;
      step <= step_n;
      cnt <= (state == SHOW && nxt == SHOW) ? cnt + 1'b1 : '0;
      fb_adr <= {plane_n, pos_n};
      lsr_c <= nxt == CLKH;
      lsr_clr <= nxt == IDLE || nxt == CLR;
      psr_c <= nxt == PSR_H;
      psr_d <= nxt == PSR_H && plane == 4'd0;
      col_enable <= nxt == SHOW;
      frame_done <= show_end && last_plane && wrap && enable;
    end
  farbborg_pwm_cmp #(.PWM_BITS(PWM_BITS)) u_cmp (
    .clk(clk),
    .reset(reset),
    .load(state == DATA),
    .step(step),
    .fb_dat(fb_dat),
    .col_data(col_data)
  );
endmodule

// File: tb/tb_farbborg_scan.sv
// tb_farbborg_scan: timeline model of the scan (cycle index since start -> expected outputs)
// with random enable/reset/frame-buffer traffic, plus literal checks that pin the model.
module tb_farbborg_scan;
  localparam int NP = 2, LL = 2, PB = 2, ON = 3;
  localparam int PER = 4 * LL + 2 + ON;
  localparam int NSTEP = (1 << PB) - 1;
  logic clk = 0, reset = 1, enable = 0;
  logic [7:0] fb_adr, col_data;
  logic [8*PB-1:0] fb_dat = '0;
  logic lsr_c, lsr_clr, psr_c, psr_d, col_enable, frame_done;
  logic [8*PB-1:0] fbw [256];
  int tm = -1;
  int checks = 0, errors = 0;

  farbborg_scan #(.NUM_PLANES(NP), .LSR_LEN(LL), .PWM_BITS(PB), .ON_CYCLES(ON)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fb_adr(fb_adr), .fb_dat(fb_dat),
    .col_data(col_data), .lsr_c(lsr_c), .lsr_clr(lsr_clr), .psr_c(psr_c), .psr_d(psr_d),
    .col_enable(col_enable), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_dat <= fbw[fb_adr];
  // tm: -1 idle/reset, 0 the clear cycle, then one count per cycle of scanning
  always @(posedge clk or posedge reset)
    if (reset) tm <= -1;
    else tm <= enable ? tm + 1 : -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h expected %0h", name, tm, got, exp);
    end
  endtask

  function automatic logic [7:0] cols(input logic [8*PB-1:0] w, input int s);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) c[k] = int'((w >> (PB * k)) & ((1 << PB) - 1)) > s;
    return c;
  endfunction

  always @(negedge clk) begin
    int u, g, r, pl, st, ad;
    if (tm <= 0) begin
      chk("lsr_clr", lsr_clr, 1);
      chk("lsr_c", lsr_c, 0);
      chk("psr_c", psr_c, 0);
      chk("psr_d", psr_d, 0);
      chk("col_enable", col_enable, 0);
      chk("frame_done", frame_done, 0);
      chk("fb_adr", fb_adr, 0);
    end else begin
      u = tm - 1; g = u / PER; r = u % PER;
      pl = g % NP; st = (g / NP) % NSTEP;
      chk("lsr_clr", lsr_clr, 0);
      chk("lsr_c", lsr_c, 32'(r < 4 * LL && r % 4 == 2));
      chk("psr_c", psr_c, 32'(r == 4 * LL));
      chk("psr_d", psr_d, 32'(r == 4 * LL && pl == 0));
      chk("col_enable", col_enable, 32'(r >= 4 * LL + 2));
      chk("frame_done", frame_done, 32'(r == 0 && g > 0 && g % (NP * NSTEP) == 0));
      if (r < 4 * LL) begin
        ad = pl * 16 + r / 4;
        if (r % 4 < 2) chk("fb_adr", fb_adr, 32'(ad));
        else chk("col_data", col_data, 32'(cols(fbw[ad], st)));
      end
    end
  end

  task automatic goto(input int target);
    int guard = 0;
    while (tm != target && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (tm != target) begin
      errors++;
      $display("FAIL timeout waiting for t=%0d got t=%0d", target, tm);
    end
  endtask

  task automatic fill;
    for (int a = 0; a < 256; a++)
      case ($urandom_range(0, 3))
        0: fbw[a] = '0;
        1: fbw[a] = '1;
        default: fbw[a] = (8*PB)'($urandom);
      endcase
  endtask

  initial begin
    fill();
    fbw[8'h00] = 16'b00_01_10_11_11_10_01_00;
    fbw[8'h01] = '1;
    fbw[8'h10] = '0;
    repeat (3) @(negedge clk);
    chk("rst lsr_clr", lsr_clr, 1);
    chk("rst col_enable", col_enable, 0);
    chk("rst fb_adr", fb_adr, 0);
    reset = 0;
    @(negedge clk);
    enable = 1;
    goto(0);  chk("clr high", lsr_clr, 1);
    goto(1);  chk("clr low", lsr_clr, 0);
    goto(3);  chk("lsr_c pos0", lsr_c, 1);
    goto(7);  chk("lsr_c pos1", lsr_c, 1);
    chk("all max lanes", col_data, 8'hFF);
    goto(9);  chk("psr_c p0", psr_c, 1); chk("psr_d p0", psr_d, 1);
    goto(11); chk("show first", col_enable, 1);
    goto(13); chk("show last", col_enable, 1);
    goto(14); chk("show off", col_enable, 0);
    goto(16); chk("all zero lanes", col_data, 8'h00);
    goto(22); chk("psr_c p1", psr_c, 1); chk("psr_d p1", psr_d, 0);
    goto(29); chk("step1 lanes", col_data, 8'b0011_1100);
    goto(79); chk("frame_done pulse", frame_done, 1);
    goto(80); chk("frame_done end", frame_done, 0);
    goto(81); chk("clkh before drop", lsr_c, 1);
    enable = 0;
    @(negedge clk);
    chk("drop lsr_c", lsr_c, 0);
    chk("drop col_enable", col_enable, 0);
    chk("drop lsr_clr", lsr_clr, 1);
    enable = 1;
    goto(12); chk("reshow", col_enable, 1);
    #1 reset = 1;
    #1;
    chk("async col_enable", col_enable, 0);
    chk("async lsr_clr", lsr_clr, 1);
    chk("async fb_adr", fb_adr, 0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(5, 200)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        #1 reset = 1;
        @(negedge clk) reset = 0;
      end else begin
        enable = 0;
        @(negedge clk);
        fill();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        enable = 1;
      end
    end
    enable = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
